// File: rtl/mem_sequencer_ncores.sv
// Sequences one memory access per enabled core lane through a single-port
// data memory, capturing read data back into per-lane result slots.
module mem_sequencer_ncores #(
  parameter int N_CORES = 4,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        MRead,
  input  logic                        MWrite,
  input  logic [N_CORES-1:0]          en,
  input  logic [N_CORES*ADDR_W-1:0]   addr_flat,
  input  logic [N_CORES*DATA_W-1:0]   wdata_flat,
  output logic [N_CORES*DATA_W-1:0]   rdata_flat,
  output logic                        MReady,
  output logic                        busy,
  output logic                        err_req,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_wren,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int LANE_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  // Tag stages below the capture stage; all clear means the last read lands now.
  localparam logic [MEM_LAT-1:0] LOW_MASK = MEM_LAT'((1 << (MEM_LAT - 1)) - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                            state_q, state_d;
  logic [N_CORES-1:0]                pend_q, pend_d;
  logic [N_CORES*ADDR_W-1:0]         addr_q, addr_d;
  logic [N_CORES*DATA_W-1:0]         wdata_q, wdata_d;
  logic                              op_wr_q, op_wr_d;
  logic                              err_q, err_d;
  logic [ADDR_W-1:0]                 mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]                 mem_wdata_q, mem_wdata_d;
  logic                              mem_wren_q, mem_wren_d;
  logic [N_CORES*DATA_W-1:0]         rdata_q, rdata_d;
  logic [MEM_LAT-1:0]                tv_q, tv_d;
  logic [MEM_LAT-1:0][LANE_W-1:0]    tag_q, tag_d;

  logic                              accept, issue, src_wr;
  logic [N_CORES-1:0]                src_mask;
  logic [N_CORES*ADDR_W-1:0]         src_addr;
  logic [N_CORES*DATA_W-1:0]         src_wdata;
  logic [LANE_W-1:0]                 lane_sel;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_d     = state_q;
    pend_d      = pend_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    op_wr_d     = op_wr_q;
    err_d       = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wren_d  = 1'b0;
    rdata_d     = rdata_q;
    tv_d        = '0;
    tag_d       = '0;

    for (int j = 1; j < MEM_LAT; j++) begin
      tv_d[j]  = tv_q[j-1];
      tag_d[j] = tag_q[j-1];
    end
    if (tv_q[MEM_LAT-1])
      rdata_d[int'(tag_q[MEM_LAT-1])*DATA_W +: DATA_W] = mem_rdata;

    // The first lane issues on the accept edge straight from the request inputs.
    accept    = (state_q == S_IDLE) && (MRead ^ MWrite);
    src_mask  = accept ? en         : pend_q;
    src_addr  = accept ? addr_flat  : addr_q;
    src_wdata = accept ? wdata_flat : wdata_q;
    src_wr    = accept ? MWrite     : op_wr_q;

    // NOTE: blocking assignments here let the descending scan leave the lowest set lane.
    lane_sel = '0;
    for (int i = N_CORES - 1; i >= 0; i--)
      if (src_mask[i]) lane_sel = LANE_W'(i);

    issue = (accept || state_q == S_ISSUE) && (src_mask != '0);
    if (issue) begin
      mem_addr_d = src_addr[int'(lane_sel)*ADDR_W +: ADDR_W];
      pend_d     = src_mask & (src_mask - N_CORES'(1));
      if (src_wr) begin
        mem_wdata_d = src_wdata[int'(lane_sel)*DATA_W +: DATA_W];
        mem_wren_d  = 1'b1;
      end else begin
        tv_d[0]  = 1'b1;
        tag_d[0] = lane_sel;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (MRead && MWrite) begin
          err_d = 1'b1;
        end else if (accept) begin
          addr_d  = addr_flat;
          wdata_d = wdata_flat;
          op_wr_d = MWrite;
          state_d = (en == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: if (pend_q == '0) state_d = (!op_wr_q && MEM_LAT > 1) ? S_DRAIN : S_DONE;
      S_DRAIN: if ((tv_q & LOW_MASK) == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the result slots are architecturally visible, so they are reset with the rest.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pend_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      op_wr_q     <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wren_q  <= 1'b0;
      rdata_q     <= '0;
      tv_q        <= '0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      op_wr_q     <= op_wr_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wren_q  <= mem_wren_d;
      rdata_q     <= rdata_d;
      tv_q        <= tv_d;
      tag_q       <= tag_d;
    end
  end

  assign rdata_flat = rdata_q;
  assign MReady     = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign err_req    = err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wren   = mem_wren_q;

endmodule

// File: tb/tb_mem_sequencer_ncores.sv
// Directed bench: two sequencers (read latency 1 and 2), each with a
// negedge-clocked memory model, driven from a vector table plus corner sequences.
module tb_mem_sequencer_ncores;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, load;
  logic [3:0]  en;
  logic [63:0] addr_flat, wdata_flat;
  logic        mread1, mwrite1, mread2, mwrite2;

  logic [63:0] rdata1, rdata2;
  logic        rdy1, rdy2, busy1, busy2, err1, err2, wren1, wren2;
  logic [15:0] maddr1, maddr2, mwdata1, mwdata2, mrdata1, mrdata2, r2_s0;
  logic [15:0] mem1 [256];
  logic [15:0] mem2 [256];

  mem_sequencer_ncores #(.N_CORES(4), .DATA_W(16), .ADDR_W(16), .MEM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .MRead(mread1), .MWrite(mwrite1), .en(en),
    .addr_flat(addr_flat), .wdata_flat(wdata_flat), .rdata_flat(rdata1),
    .MReady(rdy1), .busy(busy1), .err_req(err1), .mem_addr(maddr1),
    .mem_wdata(mwdata1), .mem_wren(wren1), .mem_rdata(mrdata1));

  mem_sequencer_ncores #(.N_CORES(4), .DATA_W(16), .ADDR_W(16), .MEM_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .MRead(mread2), .MWrite(mwrite2), .en(en),
    .addr_flat(addr_flat), .wdata_flat(wdata_flat), .rdata_flat(rdata2),
    .MReady(rdy2), .busy(busy2), .err_req(err2), .mem_addr(maddr2),
    .mem_wdata(mwdata2), .mem_wren(wren2), .mem_rdata(mrdata2));

  // Memories clocked on the inverted clock; latency 2 adds one more stage.
  always @(negedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem1[i] <= 16'(i * 3 + 7);
    end else begin
      if (wren1) mem1[maddr1[7:0]] <= mwdata1;
      mrdata1 <= mem1[maddr1[7:0]];
    end
  end

  always @(negedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem2[i] <= 16'(i * 3 + 7);
    end else begin
      if (wren2) mem2[maddr2[7:0]] <= mwdata2;
      r2_s0   <= mem2[maddr2[7:0]];
      mrdata2 <= r2_s0;
    end
  end

  typedef struct packed {
    logic             l2;
    logic             wr;
    logic [3:0]       en;
    logic [3:0][15:0] addr;
    logic [3:0][15:0] wdata;
    logic [3:0][15:0] exp_rd;
    logic [7:0]       exp_ready;
  } vec_t;

  int n_vec  = 0;
  int n_fail = 0;
  vec_t tbl [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic l2, input logic wr, input logic [3:0] e,
                              input logic [63:0] a, input logic [63:0] d,
                              input logic [63:0] r, input int rdy);
    vec_t v;
    v.l2 = l2; v.wr = wr; v.en = e; v.addr = a; v.wdata = d; v.exp_rd = r;
    v.exp_ready = 8'(rdy);
    return v;
  endfunction

  task automatic run(input int id, input vec_t v);
    logic [15:0] exp_addr [$];
    logic [15:0] a;
    logic        w, b, r;
    logic [63:0] rd;
    int wr_cnt = 0, busy_cnt = 0, cyc = 1;
    logic done = 1'b0;
    for (int i = 0; i < 4; i++) if (v.en[i]) exp_addr.push_back(v.addr[i]);
    @(negedge clk);
    en = v.en; addr_flat = v.addr; wdata_flat = v.wdata;
    if (v.l2) begin mread2 = !v.wr; mwrite2 = v.wr; end
    else      begin mread1 = !v.wr; mwrite1 = v.wr; end
    @(negedge clk);
    {mread1, mwrite1, mread2, mwrite2} = '0;
    while (!done && cyc < 40) begin
      a  = v.l2 ? maddr2 : maddr1;
      w  = v.l2 ? wren2  : wren1;
      b  = v.l2 ? busy2  : busy1;
      r  = v.l2 ? rdy2   : rdy1;
      rd = v.l2 ? rdata2 : rdata1;
      if (cyc <= exp_addr.size())
        check($sformatf("v%0d issue%0d mem_addr", id, cyc), 64'(a), 64'(exp_addr[cyc-1]));
      if (w) wr_cnt++;
      if (b) busy_cnt++;
      if (r) begin
        done = 1'b1;
        check($sformatf("v%0d MReady cycle", id), 64'(cyc), 64'(v.exp_ready));
        check($sformatf("v%0d rdata_flat", id), rd, v.exp_rd);
        check($sformatf("v%0d write cycles", id), 64'(wr_cnt),
              v.wr ? 64'($countones(v.en)) : 64'd0);
        check($sformatf("v%0d busy cycles", id), 64'(busy_cnt), 64'(v.exp_ready));
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check($sformatf("v%0d MReady seen", id), 64'(done), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    int rdy_cnt, wr_cnt, err_cnt;
    tbl[0]  = mk(0, 0, 4'b0110, {16'd13, 16'd12, 16'd11, 16'd10}, 64'd0,
                 {16'd0, 16'd43, 16'd40, 16'd0}, 3);
    tbl[1]  = mk(0, 1, 4'b1111, {16'd23, 16'd22, 16'd21, 16'd20}, {16'd24, 16'd55, 16'd20, 16'd9},
                 {16'd0, 16'd43, 16'd40, 16'd0}, 5);
    tbl[2]  = mk(0, 0, 4'b1111, {16'd23, 16'd22, 16'd21, 16'd20}, 64'd0,
                 {16'd24, 16'd55, 16'd20, 16'd9}, 5);
    tbl[3]  = mk(0, 0, 4'b0000, {16'd1, 16'd2, 16'd3, 16'd4}, 64'd0,
                 {16'd24, 16'd55, 16'd20, 16'd9}, 1);
    tbl[4]  = mk(0, 0, 4'b1000, {16'd5, 16'd0, 16'd0, 16'd0}, 64'd0,
                 {16'd22, 16'd55, 16'd20, 16'd9}, 2);
    tbl[5]  = mk(0, 1, 4'b0101, {16'd0, 16'd31, 16'd0, 16'd30}, {16'd0, 16'd200, 16'd0, 16'd100},
                 {16'd22, 16'd55, 16'd20, 16'd9}, 3);
    tbl[6]  = mk(0, 0, 4'b0111, {16'd0, 16'd7, 16'd30, 16'd31}, 64'd0,
                 {16'd22, 16'd28, 16'd100, 16'd200}, 4);
    tbl[7]  = mk(1, 0, 4'b1011, {16'd6, 16'd0, 16'd4, 16'd3}, 64'd0,
                 {16'd25, 16'd0, 16'd19, 16'd16}, 5);
    tbl[8]  = mk(1, 1, 4'b0001, {16'd0, 16'd0, 16'd0, 16'd50}, {16'd0, 16'd0, 16'd0, 16'd777},
                 {16'd25, 16'd0, 16'd19, 16'd16}, 2);
    tbl[9]  = mk(1, 0, 4'b0001, {16'd0, 16'd0, 16'd0, 16'd50}, 64'd0,
                 {16'd25, 16'd0, 16'd19, 16'd777}, 3);
    tbl[10] = mk(0, 0, 4'b0011, {16'd0, 16'd0, 16'd61, 16'd60}, 64'd0,
                 {16'd0, 16'd0, 16'd190, 16'd1}, 3);

    reset = 1'b0; load = 1'b1;
    {mread1, mwrite1, mread2, mwrite2} = '0;
    en = '0; addr_flat = '0; wdata_flat = '0;
    repeat (3) @(negedge clk);
    check("reset ctrl dut1", {28'd0, rdy1, busy1, err1, wren1, maddr1, mwdata1}, 64'd0);
    check("reset rdata dut1", rdata1, 64'd0);
    check("reset ctrl dut2", {28'd0, rdy2, busy2, err2, wren2, maddr2, mwdata2}, 64'd0);
    check("reset rdata dut2", rdata2, 64'd0);
    reset = 1'b1; load = 1'b0;

    for (int i = 0; i < 10; i++) run(i, tbl[i]);

    // Latency-2 capture timing: lane 0 lands at end of cycle 2, lane 1 at end of cycle 3.
    @(negedge clk);
    en = 4'b0011; addr_flat = {16'd0, 16'd0, 16'd9, 16'd8}; mread2 = 1'b1;
    @(negedge clk); mread2 = 1'b0;
    @(negedge clk);
    check("lat2 c2 lane0", 64'(rdata2[15:0]), 64'd777);
    @(negedge clk);
    check("lat2 c3 lane0", 64'(rdata2[15:0]), 64'd31);
    check("lat2 c3 lane1", 64'(rdata2[31:16]), 64'd19);
    check("lat2 c3 MReady", 64'(rdy2), 64'd0);
    @(negedge clk);
    check("lat2 c4 lane1", 64'(rdata2[31:16]), 64'd34);
    check("lat2 c4 MReady", 64'(rdy2), 64'd1);

    // Both requests at once in IDLE.
    @(negedge clk);
    mread1 = 1'b1; mwrite1 = 1'b1;
    @(negedge clk); mread1 = 1'b0; mwrite1 = 1'b0;
    check("illegal err_req c1", 64'(err1), 64'd1);
    check("illegal busy c1", 64'(busy1), 64'd0);
    @(negedge clk);
    check("illegal c2 err/busy/MReady", {61'd0, err1, busy1, rdy1}, 64'd0);

    // Requests re-pulsed while busy are ignored.
    @(negedge clk);
    en = 4'b1111; addr_flat = {16'd43, 16'd42, 16'd41, 16'd40};
    wdata_flat = {16'd4, 16'd3, 16'd2, 16'd1}; mwrite1 = 1'b1;
    @(negedge clk); mwrite1 = 1'b0;
    rdy_cnt = 0; wr_cnt = 0; err_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      if (rdy1) rdy_cnt++;
      if (wren1) wr_cnt++;
      if (err1) err_cnt++;
      if (c == 2) begin mwrite1 = 1'b1; mread1 = 1'b1; end
      if (c == 3) begin mwrite1 = 1'b0; mread1 = 1'b0; end
      @(negedge clk);
    end
    check("busy-ignore MReady count", 64'(rdy_cnt), 64'd1);
    check("busy-ignore write cycles", 64'(wr_cnt), 64'd4);
    check("busy-ignore err_req count", 64'(err_cnt), 64'd0);
    check("busy-ignore mem[43]", 64'(mem1[43]), 64'd4);

    // Reset asserted in the second issue cycle of a write.
    en = 4'b1111; addr_flat = {16'd63, 16'd62, 16'd61, 16'd60};
    wdata_flat = {16'd4, 16'd3, 16'd2, 16'd1}; mwrite1 = 1'b1;
    @(negedge clk); mwrite1 = 1'b0;
    check("abort c1 mem_wren", 64'(wren1), 64'd1);
    check("abort c1 mem_addr", 64'(maddr1), 64'd60);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check("abort mem_wren async", 64'(wren1), 64'd0);
    check("abort busy async", 64'(busy1), 64'd0);
    repeat (2) @(negedge clk);
    check("abort mem[60]", 64'(mem1[60]), 64'd1);
    check("abort mem[61]", 64'(mem1[61]), 64'd190);
    reset = 1'b1;
    rdy_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rdy1) rdy_cnt++;
    end
    check("abort no MReady", 64'(rdy_cnt), 64'd0);
    run(10, tbl[10]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
